// File: rtl/button_reader.sv
// Two-flop synchroniser, debounce FSM and press-length timer for one raw pushbutton.
// Define BTN_LONG_PRESS_EN to enable long_pulse; otherwise it is held at 0.
module button_reader #(
  parameter int unsigned DEBOUNCE_CYCLES = 12000,
  parameter int unsigned LONG_CYCLES     = 12000000,
  parameter int unsigned DUR_W           = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_in,
  output logic             btn_level,
  output logic             press_pulse,
  output logic             release_pulse,
  output logic             long_pulse,
  output logic [DUR_W-1:0] press_len,
  output logic             press_len_valid
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 1) begin : g_param_err
    $error("button_reader: DEBOUNCE_CYCLES must be >= 2 and LONG_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;

  state_t            state_q, state_d;
  logic              s1_q, btn_s_q;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [DUR_W-1:0]  dur_q, dur_d, dur_inc;
  logic [DUR_W-1:0]  len_q, len_d;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              rel_q, rel_d;

  assign dur_inc = (dur_q == '1) ? dur_q : dur_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    db_cnt_d = db_cnt_q;
    dur_d    = dur_q;
    len_d    = len_q;
    level_d  = level_q;
    press_d  = 1'b0;
    rel_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_s_q) begin
          state_d  = PRESS_DB;
          db_cnt_d = '0;
        end
      end
      PRESS_DB: begin
        if (!btn_s_q) begin
          state_d = IDLE;
        end else if (db_cnt_q == DB_MAX) begin
          state_d = HELD;
          press_d = 1'b1;
          level_d = 1'b1;
          dur_d   = '0;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      HELD: begin
        dur_d = dur_inc;
        if (!btn_s_q) begin
          state_d  = REL_DB;
          db_cnt_d = '0;
        end
      end
      REL_DB: begin
        dur_d = dur_inc;
        if (btn_s_q) begin
          state_d = HELD;
        end else if (db_cnt_q == DB_MAX) begin
          // Latch the post-increment count so press_len spans HELD entry to REL_DB exit.
          state_d = IDLE;
          rel_d   = 1'b1;
          level_d = 1'b0;
          len_d   = dur_inc;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= 1'b0;
      btn_s_q  <= 1'b0;
      state_q  <= IDLE;
      db_cnt_q <= '0;
      dur_q    <= '0;
      len_q    <= '0;
      level_q  <= 1'b0;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
    end else begin
      s1_q     <= btn_in;
      btn_s_q  <= s1_q;
      state_q  <= state_d;
      db_cnt_q <= db_cnt_d;
      dur_q    <= dur_d;
      len_q    <= len_d;
      level_q  <= level_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
    end
  end

`ifdef BTN_LONG_PRESS_EN
  localparam logic [DUR_W-1:0] LONG_M1 = DUR_W'(LONG_CYCLES - 1);

  logic long_q, long_d;

  // dur only changes while timing a press (or resets on HELD entry), so a
  // changed value hitting the threshold happens exactly once per press.
  assign long_d = (dur_d == LONG_M1) && (press_d || (dur_d != dur_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) long_q <= 1'b0;
    else        long_q <= long_d;
  end

  assign long_pulse = long_q;
`else
  assign long_pulse = 1'b0;
`endif

  assign btn_level       = level_q;
  assign press_pulse     = press_q;
  assign release_pulse   = rel_q;
  assign press_len_valid = rel_q;
  assign press_len       = len_q;

endmodule
